and_unit_arbiter: RTL and testbench
===================================

Name: and_unit_arbiter

Overview:
- Shares one registered bitwise-AND datapath among NUM_REQ requesters.
- Each requester presents an operand pair under valid/ready. The arbiter grants one requester per cycle using round-robin.
- The result is registered and returned with the winning requester's ID on a single response channel.
- Sits between requester blocks and the shared AND unit in the top-level integration.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, operand/result width in bits
ID_W, $clog2(NUM_REQ), requester ID width (derived, localparam)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_a  input  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  input  NUM_REQ*DATA_W  operand B, same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  downstream accepts result
rsp_data  output  DATA_W  registered a & b of granted requester
rsp_id  output  ID_W  index of granted requester

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, state=IDLE. While rst_n=0, req_ready=0 combinationally.
- Output slot:
  - One result register.
  - can_issue = !rsp_valid | rsp_ready (load on same cycle as drain allowed).
- Grant:
  - When can_issue, req_ready carries exactly one bit: the first set req_valid bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - When !can_issue or no req_valid, req_ready=0.
  - req_ready depends combinationally on req_valid, rr_ptr, rsp_valid and rsp_ready.
- Transfer:
  - Occurs when req_valid[g] & req_ready[g].
  - Next edge: rsp_data<=a[g]&b[g], rsp_id<=g, rsp_valid<=1, rr_ptr<=(g+1) mod NUM_REQ. The wrap uses an explicit compare, not a power-of-2 mask.
- Latency: 1 cycle from accepted request to rsp_valid.
- Throughput: 1 result/cycle while rsp_ready=1.
- Response:
  - rsp_valid & rsp_ready with no new transfer → rsp_valid<=0. rsp_data and rsp_id hold their last value.
  - rsp_data and rsp_id are stable while rsp_valid & !rsp_ready.
- State machine (2 states):
  - IDLE (rsp_valid=0) → FULL on transfer.
  - FULL → FULL on drain+transfer or on stall.
  - FULL → IDLE on drain without transfer.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- rr_ptr advances only on a transfer, never on an idle or stall cycle.
- Requesters must hold req_a/req_b stable while valid and not granted. The arbiter does not latch operands before a transfer.
- Reset mid-operation: a pending result is dropped, rsp_valid falls immediately, rr_ptr returns to 0.

Optional Feature:
- Macro: AND_UNIT_ARBITER_STATS_EN.
- When defined:
  - Adds output grant_cnt (NUM_REQ*16 bits): per-requester 16-bit saturating transfer counters, cleared by rst_n.
  - Adds input stats_clr (1 bit): synchronous clear of all counters. A clear has priority over an increment in the same cycle.
  - Counters saturate at 16'hFFFF.
- When undefined: neither port exists, no counter logic; all other behaviour is identical.

Decomposition:
- Package and_unit_arbiter_pkg holds:
  - DATA_W_DEFAULT, NUM_REQ_DEFAULT
  - typedef arb_state_e {IDLE, FULL}
  - function rr_pick(valid, ptr) returning found flag + index, shared with the bench model
- One sub-module: and_unit_rr_pick. It is combinational, NUM_REQ-parameterised, and takes valid and rr_ptr in, giving a one-hot grant plus an index out.
- The top holds the output register, FSM, pointer and optional counters.

Test Plan:
- Reset then single requester: NUM_REQ=4, req_valid=4'b0100, a=8'hF0, b=8'h3C, rsp_ready=1 → req_ready=4'b0100 same cycle; next cycle rsp_valid=1, rsp_data=8'h30, rsp_id=2.
- Round-robin: all four valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles; each rsp_data matches its pair.
- Backpressure: rsp_ready=0 for 3 cycles with a result held → req_ready=0 throughout, rsp_data/rsp_id unchanged. rsp_ready=1 → drain and new grant in the same cycle, no bubble.
- Wrap/skip: rr_ptr=3, req_valid=4'b0011 → grant requester 0, then requester 1, with rr_ptr wrapping correctly.
- Async reset mid-stall: assert rst_n=0 while rsp_valid=1 → rsp_valid=0 and req_ready=0 immediately; after release, the first grant goes to the lowest valid index.
- With AND_UNIT_ARBITER_STATS_EN:
  - 5 transfers to requester 1 → grant_cnt[1]=5.
  - stats_clr coincident with a transfer → counter reads 0.
  - Force a counter to 16'hFFFF and grant again → it stays 16'hFFFF.

Source files
------------

// File: rtl/and_unit_arbiter_pkg.sv
// Shared types and helpers for the round-robin AND-unit arbiter.
// The round-robin pick function is written for up to 16 requesters so the
// same code serves the RTL selector and any behavioural model.
package and_unit_arbiter_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int DATA_W_DEFAULT  = 8;

    // Widest configuration the pick helper supports.
    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = 4;

    // IDLE: the result slot is empty. FULL: the slot holds a result.
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo num_req.
    // Offsets are scanned from the far end down, so the nearest hit wins.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0]   valid,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  num_req
    );
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int off = RR_MAX - 1; off >= 0; off--) begin
            if (off < num_req) begin
                cand = int'(ptr) + off;
                if (cand >= num_req) begin
                    cand = cand - num_req;
                end
                if (valid[RR_IDX_W'(cand)]) begin
                    res.found = 1'b1;
                    res.idx   = RR_IDX_W'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/and_unit_rr_pick.sv
// Combinational round-robin selector: given the valid vector and the
// current priority pointer, returns a one-hot grant and its index.
module and_unit_rr_pick
    import and_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_found,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    logic [RR_MAX-1:0]   w_valid_pad;
    logic [RR_IDX_W-1:0] w_ptr_pad;
    rr_pick_t            w_pick;

    assign w_valid_pad = RR_MAX'(i_valid);
    assign w_ptr_pad   = RR_IDX_W'(i_ptr);
    assign w_pick      = rr_pick(w_valid_pad, w_ptr_pad, NUM_REQ);

    assign o_found = w_pick.found;
    assign o_idx   = ID_W'(w_pick.idx);

    // One-hot decode of the chosen index; all zero when nothing is valid.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : gen_grant
            assign o_grant[gi] = w_pick.found && (w_pick.idx == RR_IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise-AND unit among
// NUM_REQ requesters, with a single result slot on the response side.
// Optional per-requester grant counters are enabled by defining
// AND_UNIT_ARBITER_STATS_EN.
module and_unit_arbiter
    import and_unit_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEFAULT,
    parameter  int DATA_W  = DATA_W_DEFAULT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id
`ifdef AND_UNIT_ARBITER_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    arb_state_e          r_state;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;
    logic [ID_W-1:0]     r_rr_ptr;

    logic                w_found;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_can_issue;
    logic                w_issue_en;
    logic                w_xfer;
    logic                w_drain;
    logic [DATA_W-1:0]   w_and;
    logic [ID_W-1:0]     w_ptr_next;

    and_unit_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // The slot can take a new result when empty or draining this cycle.
    // Grants are masked while reset is asserted so nothing is accepted then.
    assign w_can_issue = !r_rsp_valid || rsp_ready;
    assign w_issue_en  = rst_n && w_can_issue;
    assign req_ready   = w_issue_en ? w_grant : '0;
    assign w_xfer      = w_issue_en && w_found;
    assign w_drain     = r_rsp_valid && rsp_ready;

    // Operand mux for the winner; operands are used directly, not latched.
    assign w_and = req_a[w_idx*DATA_W +: DATA_W] & req_b[w_idx*DATA_W +: DATA_W];

    // Pointer moves just past the winner; explicit wrap so any NUM_REQ works.
    assign w_ptr_next = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    // Slot state machine; rsp_valid is a registered copy of "slot full".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_state     <= FULL;
                        r_rsp_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (w_xfer) begin
                        r_state     <= FULL;
                        r_rsp_valid <= 1'b1;
                    end else if (w_drain) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Result payload and round-robin pointer update only on a transfer,
    // so data/id hold through stalls and after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_rr_ptr   <= '0;
        end else if (w_xfer) begin
            r_rsp_data <= w_and;
            r_rsp_id   <= w_idx;
            r_rr_ptr   <= w_ptr_next;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

`ifdef AND_UNIT_ARBITER_STATS_EN
    // Per-requester saturating transfer counters; clear beats increment.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : gen_cnt
            logic [15:0] r_cnt;

            // Count transfers won by requester gi.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (stats_clr) begin
                    r_cnt <= '0;
                end else if (w_xfer && (w_idx == ID_W'(gi)) && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign grant_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter (NUM_REQ=4, DATA_W=8).
// Operand pairs: r0 FF&0F=0F, r1 AA&F0=A0, r2 F0&3C=30, r3 55&FF=55.
module tb_and_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
`ifdef AND_UNIT_ARBITER_STATS_EN
    logic        stats_clr;
    logic [63:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    and_unit_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef AND_UNIT_ARBITER_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_ids [6];
        logic [7:0] rr_dat [6];
        rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_dat = '{8'h0F, 8'hA0, 8'h30, 8'h55, 8'h0F, 8'hA0};

        rst_n     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = {8'h55, 8'hF0, 8'hAA, 8'hFF};
        req_b     = {8'hFF, 8'h3C, 8'hF0, 8'h0F};
`ifdef AND_UNIT_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        // Reset state, with all requesters asking: nothing may be granted.
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data",  32'(rsp_data),  32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Release between edges, single requester 2.
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_data",  32'(rsp_data),  32'h30);
        chk("single_id",    32'(rsp_id),    32'd2);
        req_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'd0);
        chk("drain_data",  32'(rsp_data),  32'h30);
        chk("drain_id",    32'(rsp_id),    32'd2);

        // Pointer is 3, only 0 and 1 valid: wrap to 0, then 1.
        req_valid = 4'b0011;
        #1;
        chk("wrap_ready0", 32'(req_ready), 32'b0001);
        tick();
        chk("wrap_id0",    32'(rsp_id),    32'd0);
        chk("wrap_data0",  32'(rsp_data),  32'h0F);
        chk("wrap_ready1", 32'(req_ready), 32'b0010);
        tick();
        chk("wrap_id1",    32'(rsp_id),    32'd1);
        chk("wrap_data1",  32'(rsp_data),  32'hA0);

        // Backpressure with a result held; pointer is now 2.
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid",    32'(rsp_valid), 32'd1);
            chk("bp_id",       32'(rsp_id),    32'd1);
            chk("bp_data",     32'(rsp_data),  32'hA0);
            chk("bp_ready_hd", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("bp_rel_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rel_id",    32'(rsp_id),    32'd2);
        chk("bp_rel_data",  32'(rsp_data),  32'h30);

        // Async reset while stalled with a result held.
        rsp_ready = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_data",  32'(rsp_data),  32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b0001);

        // Fairness with everyone valid: 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_id",   32'(rsp_id),   32'(rr_ids[i]));
            chk("rr_data", 32'(rsp_data), 32'(rr_dat[i]));
        end
        req_valid = 4'b0000;
        tick();
        chk("rr_end_valid", 32'(rsp_valid), 32'd0);
        chk("rr_end_id",    32'(rsp_id),    32'd1);

`ifdef AND_UNIT_ARBITER_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("cnt_clr", grant_cnt[31:0], 32'd0);
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) tick();
        chk("cnt1_five", 32'(grant_cnt[31:16]), 32'd5);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("cnt1_clrxfer", 32'(grant_cnt[31:16]), 32'd0);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        chk("cnt1_full", 32'(grant_cnt[31:16]), 32'hFFFF);
        tick();
        chk("cnt1_sat",  32'(grant_cnt[31:16]), 32'hFFFF);
        chk("cnt0_zero", 32'(grant_cnt[15:0]),  32'd0);
        req_valid = 4'b0000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
